// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcode table, payload-length lookup and FSM state type
// shared by the SPI command sequencer and its testbench-visible top.
package spi_cmd_pkg;

  localparam int MAX_PAYLOAD_BYTES_DEF = 4;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_SET_MODE     = 8'h01;
  localparam logic [7:0] OP_SET_OFFSET_X = 8'h02;
  localparam logic [7:0] OP_SET_OFFSET_Y = 8'h03;
  localparam logic [7:0] OP_SET_ALPHA    = 8'h04;
  localparam logic [7:0] OP_SET_CROP     = 8'h05;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    ISSUE,
    DISCARD
  } state_t;

  typedef struct packed {
    logic       known;
    logic [2:0] len;
  } op_info_t;

  function automatic op_info_t op_lookup(input logic [7:0] op);
    op_info_t r;
    r.known = 1'b1;
    r.len   = 3'd0;
    case (op)
      OP_NOP:          r.len = 3'd0;
      OP_SET_MODE:     r.len = 3'd1;
      OP_SET_OFFSET_X: r.len = 3'd2;
      OP_SET_OFFSET_Y: r.len = 3'd2;
      OP_SET_ALPHA:    r.len = 3'd1;
      OP_SET_CROP:     r.len = 3'd4;
      default:         r.known = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_cmd_timeout_counter.sv
// spi_cmd_timeout_counter: saturating inter-byte gap counter that
// flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
module spi_cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES));

  // count idle cycles, restart on each byte, hold at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_command_sequencer.sv
// spi_command_sequencer: frames SPI bytes into opcode+payload commands.
// Optional inter-byte timeout built when SPI_CMD_TIMEOUT_EN is defined.
module spi_command_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = MAX_PAYLOAD_BYTES_DEF,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           spi_cs_active,
  input  logic                           spi_byte_ready,
  input  logic [7:0]                     spi_byte_in,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [7:0]                     cmd_opcode,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] cmd_payload,
  output logic                           err_unknown,
  output logic                           err_truncated,
  output logic                           err_overrun
);

  localparam int PW = 8 * MAX_PAYLOAD_BYTES;

  state_t     state, state_nxt;
  logic [7:0] opcode;
  logic [PW-1:0] payload;
  logic [2:0] remaining;
  logic       discard;

  op_info_t   info;
  logic       handshake;
  logic       load_op;
  logic       shift_en;
  logic       unk_set;
  logic       trunc_set;
  logic       ovr_set;
  logic       timeout_hit;

  assign info        = op_lookup(spi_byte_in);
  assign handshake   = (state == ISSUE) && cmd_ready;
  assign cmd_valid   = (state == ISSUE);
  assign cmd_opcode  = opcode;
  assign cmd_payload = payload;

`ifdef SPI_CMD_TIMEOUT_EN
  spi_cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (spi_byte_ready),
    .enable (state == PAYLOAD),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and per-cycle action decode
  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    shift_en  = 1'b0;
    unk_set   = 1'b0;
    trunc_set = 1'b0;
    ovr_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (spi_byte_ready) begin
          if (info.known) begin
            load_op   = 1'b1;
            state_nxt = (info.len == 3'd0) ? ISSUE : PAYLOAD;
          end else begin
            unk_set   = 1'b1;
            state_nxt = DISCARD;
          end
        end
      end
      PAYLOAD: begin
        if (spi_byte_ready) begin
          shift_en = 1'b1;
          if (remaining == 3'd1) state_nxt = ISSUE;
        end else if (!spi_cs_active) begin
          trunc_set = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          trunc_set = 1'b1;
          state_nxt = DISCARD;
        end
      end
      ISSUE: begin
        ovr_set = spi_byte_ready;
        if (cmd_ready) begin
          state_nxt = (discard || spi_byte_ready) ? DISCARD : IDLE;
        end
      end
      DISCARD: begin
        if (!spi_cs_active) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command data, sticky discard flag and registered error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode        <= '0;
      payload       <= '0;
      remaining     <= '0;
      discard       <= 1'b0;
      err_unknown   <= 1'b0;
      err_truncated <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      err_unknown   <= unk_set;
      err_truncated <= trunc_set;
      err_overrun   <= ovr_set;
      if (load_op) begin
        opcode    <= spi_byte_in;
        payload   <= '0;
        remaining <= info.len;
      end
      if (shift_en) begin
        payload   <= (payload << 8) | PW'(spi_byte_in);
        remaining <= remaining - 3'd1;
      end
      if (handshake) begin
        discard <= 1'b0;
      end else if (ovr_set) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// tb_spi_command_sequencer: directed stimulus, frame-level reference
// model compared every cycle, plus literal spot checks.
module tb_spi_command_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        rdy;
  logic [7:0]  bin;
  logic        crdy;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_payload;
  logic        err_unknown;
  logic        err_truncated;
  logic        err_overrun;

  int total = 0;
  int bad   = 0;

  spi_command_sequencer #(
    .MAX_PAYLOAD_BYTES(4),
    .TIMEOUT_CYCLES   (65535)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .spi_cs_active (cs),
    .spi_byte_ready(rdy),
    .spi_byte_in   (bin),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (crdy),
    .cmd_opcode    (cmd_opcode),
    .cmd_payload   (cmd_payload),
    .err_unknown   (err_unknown),
    .err_truncated (err_truncated),
    .err_overrun   (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [7:0] op);
    case (op)
      8'h00: return 0;
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 2;
      8'h04: return 1;
      8'h05: return 4;
      default: return -1;
    endcase
  endfunction

  // frame-level reference model
  logic [7:0]  mq[$];
  logic        m_pend = 1'b0;
  logic        m_skip = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [7:0]  m_op   = '0;
  logic [31:0] m_pay  = '0;
  logic        m_unk  = 1'b0;
  logic        m_tr   = 1'b0;
  logic        m_ov   = 1'b0;

  always @(posedge clk) begin
    m_unk = 1'b0;
    m_tr  = 1'b0;
    m_ov  = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_pend = 1'b0;
      m_skip = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_pend) begin
      if (rdy) begin
        m_ov  = 1'b1;
        m_ovf = 1'b1;
      end
      if (crdy) begin
        m_pend = 1'b0;
        m_skip = m_ovf;
        m_ovf  = 1'b0;
      end
    end else if (m_skip) begin
      if (!cs) m_skip = 1'b0;
    end else if (mq.size() > 0) begin
      if (rdy) begin
        mq.push_back(bin);
        if (mq.size() == 1 + len_of(mq[0])) begin
          m_pend = 1'b1;
          m_op   = mq[0];
          m_pay  = '0;
          for (int i = 1; i < mq.size(); i++) m_pay = m_pay * 256 + 32'(mq[i]);
          mq.delete();
        end
      end else if (!cs) begin
        m_tr = 1'b1;
        mq.delete();
      end
    end else if (rdy) begin
      if (len_of(bin) < 0) begin
        m_unk  = 1'b1;
        m_skip = 1'b1;
      end else if (len_of(bin) == 0) begin
        m_pend = 1'b1;
        m_op   = bin;
        m_pay  = '0;
      end else begin
        mq.push_back(bin);
      end
    end
    #1;
    chk("m_valid", cmd_valid, m_pend);
    chk("m_unknown", err_unknown, m_unk);
    chk("m_trunc", err_truncated, m_tr);
    chk("m_overrun", err_overrun, m_ov);
    if (m_pend) begin
      chk("m_opcode", cmd_opcode, m_op);
      chk("m_payload", cmd_payload, m_pay);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rdy = 1'b1;
    bin = b;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic cs_pulse_low();
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    cs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cs    = 1'b0;
    rdy   = 1'b0;
    bin   = '0;
    crdy  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_opcode", cmd_opcode, 8'h00);
    chk("rst_payload", cmd_payload, 32'h0);
    chk("rst_errs", {err_unknown, err_truncated, err_overrun}, 3'b000);
    rst_n = 1'b1;
    cs    = 1'b1;

    // two-byte payload command
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("offx_valid", cmd_valid, 1'b1);
    chk("offx_op", cmd_opcode, 8'h02);
    chk("offx_pay", cmd_payload, 32'h0000_1234);
    @(negedge clk);
    chk("offx_drop", cmd_valid, 1'b0);

    // zero-length then back-to-back one-byte command
    send(8'h00);
    chk("nop_valid", cmd_valid, 1'b1);
    chk("nop_pay", cmd_payload, 32'h0);
    send(8'h01);
    send(8'hAB);
    chk("mode_op", cmd_opcode, 8'h01);
    chk("mode_pay", cmd_payload, 32'h0000_00AB);

    // unknown opcode discards until chip select drops
    send(8'h7F);
    chk("unk_pulse", err_unknown, 1'b1);
    send(8'h01);
    send(8'h55);
    chk("unk_novalid", cmd_valid, 1'b0);
    cs_pulse_low();

    // truncated frame
    send(8'h05);
    send(8'h01);
    send(8'h02);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    chk("trunc_pulse", err_truncated, 1'b1);
    chk("trunc_novalid", cmd_valid, 1'b0);
    cs = 1'b1;
    send(8'h04);
    send(8'h80);
    chk("alpha_op", cmd_opcode, 8'h04);
    chk("alpha_pay", cmd_payload, 32'h0000_0080);
    @(negedge clk);

    // overrun while command held
    crdy = 1'b0;
    send(8'h04);
    send(8'h80);
    send(8'h01);
    chk("ovr_pulse", err_overrun, 1'b1);
    chk("ovr_hold_v", cmd_valid, 1'b1);
    chk("ovr_hold_op", cmd_opcode, 8'h04);
    chk("ovr_hold_pay", cmd_payload, 32'h0000_0080);
    crdy = 1'b1;
    @(negedge clk);
    chk("ovr_hs_drop", cmd_valid, 1'b0);
    send(8'h00);
    chk("ovr_discard", cmd_valid, 1'b0);
    cs_pulse_low();
    send(8'h00);
    chk("ovr_recover", cmd_valid, 1'b1);

    // four-byte payload fills the whole field
    send(8'h05);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    chk("crop_pay", cmd_payload, 32'hDEAD_BEEF);

    // last byte coincides with chip select dropping
    send(8'h01);
    @(negedge clk);
    rdy = 1'b1;
    bin = 8'h33;
    cs  = 1'b0;
    @(negedge clk);
    rdy = 1'b0;
    chk("sim_valid", cmd_valid, 1'b1);
    chk("sim_pay", cmd_payload, 32'h0000_0033);
    chk("sim_notrunc", err_truncated, 1'b0);
    @(negedge clk);
    chk("sim_notrunc2", err_truncated, 1'b0);
    cs = 1'b1;

    // reset mid-payload
    send(8'h03);
    send(8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", cmd_valid, 1'b0);
    chk("mrst_op", cmd_opcode, 8'h00);
    chk("mrst_pay", cmd_payload, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01);
    send(8'h02);
    chk("post_op", cmd_opcode, 8'h01);
    chk("post_pay", cmd_payload, 32'h0000_0002);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_command_sequencer.md
# spi_command_sequencer

Frames the raw SPI byte stream from the host microcontroller into complete configuration commands: an opcode byte, then a fixed-length payload whose size depends on the opcode. It checks that each frame is complete, then presents each command to the configuration register bank through a valid/ready handshake. It sits between the SPI slave byte receiver and the register bank, and replaces fixed-count byte collection with opcode-driven sequencing.

## Interface
Parameters:
- MAX_PAYLOAD_BYTES, 4, payload capacity; cmd_payload width is 8*MAX_PAYLOAD_BYTES
- TIMEOUT_CYCLES, 65535, inter-byte timeout in clk cycles (used only with SPI_CMD_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- spi_cs_active  in  1  high while the host holds chip select; a falling edge ends the frame
- spi_byte_ready  in  1  single-cycle strobe; spi_byte_in is valid
- spi_byte_in  in  8  received byte
- cmd_valid  out  1  command available
- cmd_ready  in  1  downstream accepts the command when cmd_valid && cmd_ready
- cmd_opcode  out  8  opcode of the current command
- cmd_payload  out  8*MAX_PAYLOAD_BYTES  payload, right-aligned, first byte most significant, upper bytes zero
- err_unknown  out  1  one-cycle pulse: unknown opcode received
- err_truncated  out  1  one-cycle pulse: chip select dropped mid-payload (or timeout)
- err_overrun  out  1  one-cycle pulse: byte arrived while a command was pending

## Operation
- The opcode table lives in the package. Each entry gives an opcode and its payload length:
  - 0x00 NOP, 0 bytes
  - 0x01 SET_MODE, 1 byte
  - 0x02 SET_OFFSET_X, 2 bytes
  - 0x03 SET_OFFSET_Y, 2 bytes
  - 0x04 SET_ALPHA, 1 byte
  - 0x05 SET_CROP, 4 bytes
  - No length may exceed MAX_PAYLOAD_BYTES.
- The state machine has four states: IDLE, PAYLOAD, ISSUE, DISCARD.
- IDLE, on a byte:
  - Known opcode: latch it, clear the payload, load remaining = length. Go to ISSUE if length is 0, else to PAYLOAD.
  - Unknown opcode: pulse err_unknown and go to DISCARD.
- PAYLOAD, on a byte: shift it in (payload <= {payload << 8} | byte) and decrement remaining. When remaining reaches 0, go to ISSUE.
- PAYLOAD, on chip select inactive with no byte that cycle: pulse err_truncated and go to IDLE. No command is issued.
- ISSUE: cmd_valid is high. cmd_opcode and cmd_payload stay stable until the handshake.
  - On handshake: go to IDLE if chip select is inactive, otherwise to IDLE as well; the next byte is treated as a new opcode (back-to-back commands within one chip-select window are legal).
  - On a byte while in ISSUE: drop it, pulse err_overrun, and set a sticky discard flag. After the handshake, go to DISCARD instead of IDLE.
- DISCARD: ignore all bytes. Go to IDLE when chip select is inactive.
- Chip select dropping while in ISSUE does not cancel the pending command.
- Reset mid-frame: everything returns to IDLE and the partial frame is lost.

## Timing
- Reset values: state IDLE; cmd_valid 0; cmd_opcode 0; cmd_payload 0; all err_* 0; remaining 0.
- cmd_valid rises on the cycle after the spi_byte_ready strobe of the last payload byte, or of the opcode for 0-length commands.
- cmd_valid falls on the cycle after the handshake.
- Minimum spacing between commands is 2 cycles: handshake, then IDLE.
- Error pulses are registered and last exactly 1 cycle, one cycle after the cause.
- Simultaneous byte strobe and chip select going inactive: the byte is accepted first. If it completes the frame, the command issues and no err_truncated is raised.
- The byte receiver must not strobe faster than once per clock.

## Configuration
- SPI_CMD_TIMEOUT_EN defined:
  - A counter clears on every byte and increments while the block is in PAYLOAD.
  - On reaching TIMEOUT_CYCLES it pulses err_truncated and goes to DISCARD.
- SPI_CMD_TIMEOUT_EN undefined:
  - No counter is built and TIMEOUT_CYCLES is unused.
  - PAYLOAD waits indefinitely for a byte or for chip select to go inactive.

## Structure
- Package spi_cmd_pkg holds:
  - the opcode constants
  - the length lookup function
  - the state enum typedef
  - the MAX_PAYLOAD_BYTES default
- One sub-module, spi_cmd_timeout_counter, is instantiated only under SPI_CMD_TIMEOUT_EN.

## Test plan
- Bytes 0x02, 0x12, 0x34 with chip select active, cmd_ready=1: exactly one cmd_valid with opcode 0x02 and payload 0x00001234, 1 cycle after the 0x34 strobe.
- Byte 0x00 alone: cmd_valid with payload 0, 1 cycle after the strobe. Then 0x01, 0xAB in the same chip-select window: second command 0x01 with payload 0x000000AB.
- Byte 0x7F: err_unknown pulse. The following bytes 0x01, 0x55 are ignored until chip select goes inactive; no cmd_valid.
- 0x05, 0x01, 0x02, then chip select inactive: err_truncated pulse, no cmd_valid, state IDLE. A following 0x04, 0x80 issues normally.
- 0x04, 0x80 with cmd_ready=0, then byte 0x01: err_overrun pulse. Command 0x04/0x80 is held stable. Raise cmd_ready: one handshake, then DISCARD until chip select is inactive.
- Assert reset low mid-payload after 0x03, 0x01: all outputs return to reset values immediately. After release, 0x01, 0x02 yields command 0x01/0x00000002.
